// File: rtl/mat_row_streamer.sv
// Captures a full ROW x COL matrix in one handshake, then streams it out
// one row per out_valid/out_ready handshake, tagging each row with its index.
module mat_row_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int ROW        = 8,
    parameter int COL        = 8,
    localparam int IDX_W     = (ROW > 1) ? $clog2(ROW) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*ROW*COL-1:0] in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*COL-1:0]     out_row,
    output logic [IDX_W-1:0]              out_row_idx,
    output logic                          out_last
);

    localparam int ROW_W = DATA_WIDTH * COL;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                          state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic [DATA_WIDTH*ROW*COL-1:0]   buf_q, buf_d;
    logic [ROW_W-1:0]                rows_w [ROW];
    logic                            at_last_w;

    for (genvar g = 0; g < ROW; g++) begin : g_rows
        assign rows_w[g] = buf_q[g*ROW_W +: ROW_W];
    end

    assign at_last_w   = (cnt_q == IDX_W'(ROW - 1));
    assign in_ready    = (state_q == IDLE) && rst_n;
    assign out_valid   = (state_q == STREAM);
    assign out_row     = rows_w[cnt_q];
    assign out_row_idx = cnt_q;
    assign out_last    = out_valid && at_last_w;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    buf_d   = in;
                    cnt_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Returning to IDLE here means a pending in_valid is only seen
                // on the following edge, giving the one-cycle bubble.
                if (out_ready) begin
                    if (at_last_w) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_mat_row_streamer.sv
// Scoreboard bench: stimulus pushes expected rows, negedge monitors compare
// and pop on each handshake. Covers an 8x8 instance and a 1x4 instance.
module tb_mat_row_streamer;

    logic          clk = 1'b0;
    logic          rst_n;
    always #5 clk = ~clk;

    // 8x8, 16-bit instance
    logic          in_valid, in_ready, out_valid, out_ready, out_last;
    logic [1023:0] in;
    logic [127:0]  out_row;
    logic [2:0]    out_row_idx;

    // 1x4, 8-bit instance
    logic          b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
    logic [31:0]   b_in, b_out_row;
    logic [0:0]    b_out_row_idx;

    mat_row_streamer #(.DATA_WIDTH(16), .ROW(8), .COL(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in(in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last)
    );

    mat_row_streamer #(.DATA_WIDTH(8), .ROW(1), .COL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_row(b_out_row),
        .out_row_idx(b_out_row_idx), .out_last(b_out_last)
    );

    typedef struct {
        logic [2:0]   idx;
        logic [127:0] row;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_b_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          hs_a     = 0;
    int          hs_b     = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] mk_mat(input bit second);
        logic [1023:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                m[16*(i*8+j) +: 16] = second ? 16'(16'hFF00 + i*8 + j) : 16'((i << 8) | j);
        return m;
    endfunction

    task automatic push_rows(input logic [1023:0] m);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.idx  = 3'(i);
            e.row  = m[128*i +: 128];
            e.last = (i == 7);
            exp_q.push_back(e);
        end
    endtask

    // Monitor, 8x8 instance: head of queue must be on the bus whenever valid,
    // which also enforces stability across stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_row actual_idx=%0d actual_row=%h expected=none",
                             out_row_idx, out_row);
                end else begin
                    chk("row_data", out_row, exp_q[0].row);
                    chk("row_idx", 128'(out_row_idx), 128'(exp_q[0].idx));
                    chk("row_last", 128'(out_last), 128'(exp_q[0].last));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_a++;
                    end
                end
            end else begin
                chk("last_when_idle", 128'(out_last), 128'(0));
            end
        end
    end

    // Monitor, 1x4 instance
    always @(negedge clk) begin
        if (rst_n && b_out_valid) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_row actual=%h expected=none", b_out_row);
            end else begin
                chk("b_row", 128'(b_out_row), 128'(exp_b_q[0]));
                chk("b_idx", 128'(b_out_row_idx), 128'(0));
                chk("b_last", 128'(b_out_last), 128'(1));
                if (b_out_ready) begin
                    void'(exp_b_q.pop_front());
                    hs_b++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready (bounded); returns number of cycles waited, -1 on timeout.
    task automatic wait_ready(output int n);
        n = -1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (in_ready) begin
                n = c;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hs0;
        logic [1023:0] m1, m2;
        m1 = mk_mat(1'b0);
        m2 = mk_mat(1'b1);

        rst_n = 1'b0; in_valid = 1'b0; in = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in = '0; b_out_ready = 1'b1;
        tick(); tick();
        chk("in_ready_in_reset", 128'(in_ready), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));
        chk("out_valid_after_reset", 128'(out_valid), 128'(0));
        chk("out_row_after_reset", out_row, 128'(0));
        chk("idx_after_reset", 128'(out_row_idx), 128'(0));
        tick();

        // Basic stream, out_ready held high
        in = m1; in_valid = 1'b1; push_rows(m1);
        tick();
        in_valid = 1'b0;
        chk("latency_out_valid", 128'(out_valid), 128'(1));
        chk("in_ready_streaming", 128'(in_ready), 128'(0));
        wait_ready(n);
        chk("stream_cycles", 128'(n), 128'(8));
        chk("queue_drained_1", 128'(exp_q.size()), 128'(0));

        // Stalls: out_ready pattern 1,0,0 repeating
        hs0 = hs_a;
        in = m1; in_valid = 1'b1; push_rows(m1);
        tick();
        in_valid = 1'b0;
        n = -1;
        for (int c = 0; c < 60; c++) begin
            out_ready = (c % 3 == 0);
            tick();
            if (in_ready) begin
                n = c;
                break;
            end
        end
        out_ready = 1'b1;
        chk("stall_finished", 128'(n >= 0), 128'(1));
        chk("stall_handshakes", 128'(hs_a - hs0), 128'(8));
        chk("queue_drained_2", 128'(exp_q.size()), 128'(0));

        // in_valid held through streaming: second matrix waits for one bubble
        in = m1; in_valid = 1'b1; push_rows(m1);
        tick();
        in = m2; push_rows(m2);
        wait_ready(n);
        chk("back_to_back_gap", 128'(n), 128'(8));
        chk("bubble_out_valid", 128'(out_valid), 128'(0));
        tick();
        in_valid = 1'b0;
        chk("second_accepted", 128'(out_valid), 128'(1));
        chk("second_row0", out_row, m2[127:0]);
        wait_ready(n);
        chk("second_stream_cycles", 128'(n), 128'(8));
        chk("queue_drained_3", 128'(exp_q.size()), 128'(0));

        // Reset after three handshakes aborts the transfer
        in = m1; in_valid = 1'b1; push_rows(m1);
        tick();
        in_valid = 1'b0;
        n = -1;
        for (int c = 0; c < 30; c++) begin
            if (exp_q.size() == 5) begin
                n = c;
                break;
            end
            tick();
        end
        chk("reset_point_reached", 128'(n >= 0), 128'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        chk("abort_out_valid", 128'(out_valid), 128'(0));
        chk("abort_out_row", out_row, 128'(0));
        chk("abort_in_ready", 128'(in_ready), 128'(1));
        repeat (12) tick();

        // ROW=1 instance
        hs0 = hs_b;
        b_in = 32'hDDCCBBAA; b_in_valid = 1'b1; exp_b_q.push_back(32'hDDCCBBAA);
        tick();
        b_in_valid = 1'b0;
        chk("b_out_valid", 128'(b_out_valid), 128'(1));
        tick();
        chk("b_back_idle", 128'(b_in_ready), 128'(1));
        chk("b_out_valid_done", 128'(b_out_valid), 128'(0));
        chk("b_handshakes", 128'(hs_b - hs0), 128'(1));
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mat_row_streamer.md
MAT_ROW_STREAMER -- requirements
Module: mat_row_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: bit width of one matrix element.
REQ-002 SHALL have parameter ROW, default 8: matrix rows (>=1).
REQ-003 SHALL have parameter COL, default 8: matrix columns (>=1).
REQ-004 SHALL have derived localparam IDX_W = max(1, clog2(ROW)).
REQ-005 clk  input  1  sole clock, all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  1  flat matrix on `in` is valid.
REQ-008 in_ready  output  1  block can accept a matrix.
REQ-009 in  input  DATA_WIDTH*ROW*COL  flat matrix; element (i,j) at bits [DATA_WIDTH*(i*COL+j+1)-1 : DATA_WIDTH*(i*COL+j)]; row i occupies [DATA_WIDTH*COL*(i+1)-1 : DATA_WIDTH*COL*i].
REQ-010 out_valid  output  1  out_row holds a valid row.
REQ-011 out_ready  input  1  downstream accepts the current row.
REQ-012 out_row  output  DATA_WIDTH*COL  one row; element j at [DATA_WIDTH*(j+1)-1 : DATA_WIDTH*j].
REQ-013 out_row_idx  output  IDX_W  index of the row on out_row.
REQ-014 out_last  output  1  high when out_row_idx == ROW-1 and out_valid is high.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, STREAM.
REQ-016 in_ready SHALL equal (state == IDLE) AND rst_n, combinationally.
REQ-017 In IDLE, on in_valid && in_ready at a rising edge: SHALL capture all of `in` into an internal matrix buffer, set row counter to 0, enter STREAM.
REQ-018 out_valid SHALL equal (state == STREAM); first row valid in the cycle immediately after the accepting edge (1-cycle latency).
REQ-019 out_row SHALL be row[row counter] of the captured buffer; out_row_idx SHALL equal the row counter.
REQ-020 In STREAM, with out_valid && !out_ready: out_row, out_row_idx, out_last SHALL hold stable; counter SHALL NOT advance.
REQ-021 In STREAM, on out_valid && out_ready with counter < ROW-1: counter SHALL increment by 1.
REQ-022 In STREAM, on out_valid && out_ready with counter == ROW-1: SHALL return to IDLE, counter to 0.
REQ-023 in_valid during STREAM SHALL be ignored; buffer SHALL NOT change until next acceptance in IDLE.
REQ-024 Last-row handshake and in_valid in the same cycle: no capture that cycle; the new matrix SHALL be accepted no earlier than the following edge (one-cycle bubble).
REQ-025 ROW == 1: the first out handshake SHALL also be the last; out_last high whenever out_valid.
REQ-026 Buffer contents SHALL pass through bit-exact; no arithmetic or width change.
REQ-027 When out_valid is low, out_row SHALL still reflect buffer row[counter] (no forced zero), out_last SHALL be 0.

Reset
REQ-028 While rst_n is low at a rising edge: state IDLE, counter 0, buffer cleared to all zeros.
REQ-029 Outputs during/after reset: in_ready 0 while rst_n low, 1 in first cycle after rst_n high; out_valid 0; out_row 0; out_row_idx 0; out_last 0.
REQ-030 Reset asserted mid-STREAM SHALL abort the transfer; remaining rows SHALL NOT be emitted after reset release.

Verification
REQ-031 Defaults, element (i,j)=16'h{i,j} (e.g. 16'h0203), in_valid 1 cycle, out_ready held 1 -> rows 0..7 on 8 consecutive cycles starting 1 cycle after acceptance, out_row element j of row i = 16'h{i,j}, out_last only at idx 7, in_ready 1 the cycle after.
REQ-032 Same matrix, out_ready toggling 1,0,0,1,... -> no row skipped or duplicated; out_row and out_row_idx stable across each stall; exactly 8 handshakes.
REQ-033 in_valid held high with second matrix (element = 16'hFF00+i*8+j) during streaming of first -> first matrix emitted intact; second accepted in cycle after first's last handshake; its row 0 = 16'hFF00..16'hFF07.
REQ-034 rst_n low for 1 cycle after 3 row handshakes -> out_valid 0, out_row 0, in_ready 1 after release; no rows 3..7 appear.
REQ-035 ROW=1, COL=4, DATA_WIDTH=8, in=32'hDDCCBBAA -> single row 32'hDDCCBBAA, out_row_idx 0, out_last 1, back to IDLE after one handshake.
